// File: rtl/ps2_hex_entry.sv
// ps2_hex_entry
//
// Decodes PS/2 keyboard frames into hexadecimal digits for the
// seven-segment display path.
//
// Pipeline:
//   PS2_CLK/PS2_DATA -> 2-FF synchronisers -> glitch filter on the clock
//   -> frame FSM (start, 8 data LSB first, odd parity, stop)
//   -> set-2 make/break decoder -> hex digit and 32-bit shift value.
//
// Parameters:
//   FILTER_LEN      consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYCLES  idle cycles allowed between falling edges mid-frame
//
// Ports:
//   clk         system clock
//   CPU_RESETN  asynchronous active-low reset
//   PS2_CLK     PS/2 clock from the bridge (asynchronous)
//   PS2_DATA    PS/2 data from the bridge (asynchronous)
//   hex         last accepted digit
//   hex_valid   one-cycle pulse when hex updates
//   value       last 8 digits, newest in [3:0]
//   frame_err   one-cycle pulse when a frame is discarded

module ps2_hex_entry #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        CPU_RESETN,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [3:0]  hex,
    output logic        hex_valid,
    output logic [31:0] value,
    output logic        frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Synchronisers (idle-high bus, so reset to 1)
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_s;
    logic       data_s;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // ------------------------------------------------------------------
    // Clock glitch filter
    // The counter tracks how many consecutive samples have disagreed with
    // the current filtered level; any agreeing sample restarts it.
    // ------------------------------------------------------------------
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fclk_q, fclk_d;
    logic          fall;

    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (clk_s != fclk_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                fclk_d = clk_s;
                fall   = fclk_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            fclk_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            fclk_q <= fclk_d;
            fcnt_q <= fcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        stb_q, stb_d;
    logic [7:0]  byte_q, byte_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        err_d     = 1'b0;
        stb_d     = 1'b0;
        byte_d    = byte_q;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (fall) begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    par_d   = data_s;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    // Odd parity: data bits plus parity bit XOR to 1.
                    if (data_s && ((^shift_q) ^ par_q)) begin
                        stb_d  = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Mid-frame inactivity watchdog; only runs on cycles without an edge.
        if (state_q != StIdle) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            stb_q     <= 1'b0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            stb_q     <= stb_d;
            byte_q    <= byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Set-2 decoder
    // ------------------------------------------------------------------
    // Returns {hit, digit}.
    function automatic logic [4:0] lookup(input logic [7:0] code);
        logic [4:0] r;
        r = 5'b0_0000;
        case (code)
            8'h45: r = 5'h10;
            8'h16: r = 5'h11;
            8'h1E: r = 5'h12;
            8'h26: r = 5'h13;
            8'h25: r = 5'h14;
            8'h2E: r = 5'h15;
            8'h36: r = 5'h16;
            8'h3D: r = 5'h17;
            8'h3E: r = 5'h18;
            8'h46: r = 5'h19;
            8'h1C: r = 5'h1A;
            8'h32: r = 5'h1B;
            8'h21: r = 5'h1C;
            8'h23: r = 5'h1D;
            8'h24: r = 5'h1E;
            8'h2B: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic        brk_q, brk_d;
    logic        ext_q, ext_d;
    logic [3:0]  hex_q, hex_d;
    logic        hv_q, hv_d;
    logic [31:0] value_q, value_d;
    logic [4:0]  lk;

    assign lk = lookup(byte_q);

    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        hex_d   = hex_q;
        hv_d    = 1'b0;
        value_d = value_q;
        if (stb_q) begin
            if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                // Break or extended key: swallow the code and rearm.
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (lk[4]) begin
                hex_d   = lk[3:0];
                value_d = {value_q[27:0], lk[3:0]};
                hv_d    = 1'b1;
            end else if (byte_q == 8'h66) begin
                value_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            hex_q   <= '0;
            hv_q    <= 1'b0;
            value_q <= '0;
        end else begin
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            hex_q   <= hex_d;
            hv_q    <= hv_d;
            value_q <= value_d;
        end
    end

    assign hex       = hex_q;
    assign hex_valid = hv_q;
    assign value     = value_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Scoreboard bench for ps2_hex_entry: directed PS/2 frames push expected
// events into a queue; a monitor pops one per hex_valid/frame_err pulse.

module tb_ps2_hex_entry;

    localparam int unsigned FLEN = 8;
    localparam int unsigned TMO  = 1000;
    localparam int          HALF = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [3:0]  hex;
    logic        hex_valid;
    logic [31:0] value;
    logic        frame_err;

    always #5 clk = ~clk;

    ps2_hex_entry #(
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .CPU_RESETN (rst_n),
        .PS2_CLK    (ps2_clk),
        .PS2_DATA   (ps2_data),
        .hex        (hex),
        .hex_valid  (hex_valid),
        .value      (value),
        .frame_err  (frame_err)
    );

    typedef struct packed {
        logic        is_err;
        logic [3:0]  hex;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int hv_cnt = 0;
    int fe_cnt = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic exp_hex(input logic [3:0] h, input logic [31:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.hex = h;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1;
        e.hex = '0;
        e.val = '0;
        q.push_back(e);
    endtask

    // Drives the first n bits of an 11-bit frame, LSB (start) first.
    task automatic send_raw(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        cyc(100);
    endtask

    task automatic send(input logic [7:0] b, input logic par_flip = 1'b0,
                        input logic stop = 1'b1);
        logic par;
        par = (~^b) ^ par_flip;
        send_raw({stop, par, b, 1'b0}, 11);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            cyc(1);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending events want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hex_valid || frame_err) begin
                if (hex_valid) hv_cnt++;
                if (frame_err) fe_cnt++;
                total++;
                if (hex_valid && frame_err) begin
                    bad++;
                    $display("FAIL overlap: got hex_valid=1 frame_err=1 want exclusive");
                end
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected: got hv=%b fe=%b hex=%h value=%h want none",
                             hex_valid, frame_err, hex, value);
                end else begin
                    e = q.pop_front();
                    if (e.is_err) begin
                        if (!frame_err) begin
                            bad++;
                            $display("FAIL event: got hex_valid want frame_err");
                        end
                    end else if (!hex_valid || hex !== e.hex || value !== e.val) begin
                        bad++;
                        $display("FAIL event: got hv=%b hex=%h value=%h want hv=1 hex=%h value=%h",
                                 hex_valid, hex, value, e.hex, e.val);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int hv0;
        int fe0;
        cyc(5);
        check("rst_hex", {28'd0, hex}, 32'h0);
        check("rst_value", value, 32'h0);
        check("rst_pulses", {30'd0, hex_valid, frame_err}, 32'h0);
        rst_n = 1'b1;
        cyc(20);

        // Single key
        exp_hex(4'h1, 32'h0000_0001);
        send(8'h16);
        drain();

        // Wrap sequence
        fe0 = fe_cnt;
        exp_hex(4'hA, 32'h0000_001A); send(8'h1C);
        exp_hex(4'hB, 32'h0000_01AB); send(8'h32);
        exp_hex(4'hC, 32'h0000_1ABC); send(8'h21);
        exp_hex(4'hD, 32'h0001_ABCD); send(8'h23);
        exp_hex(4'hE, 32'h001A_BCDE); send(8'h24);
        exp_hex(4'hF, 32'h01AB_CDEF); send(8'h2B);
        exp_hex(4'h0, 32'h1ABC_DEF0); send(8'h45);
        exp_hex(4'h1, 32'hABCD_EF01); send(8'h16);
        exp_hex(4'h2, 32'hBCDE_F012); send(8'h1E);
        drain();
        check("seq_value", value, 32'hBCDE_F012);
        check("seq_no_err", fe_cnt - fe0, 0);

        // Backspace
        send(8'h66);
        drain();
        check("bksp_value", value, 32'h0);

        // Break / extended handling
        hv0 = hv_cnt;
        exp_hex(4'h2, 32'h0000_0002);
        send(8'h1E);
        send(8'hF0); send(8'h1E);
        send(8'hE0); send(8'h1E);
        send(8'hE0); send(8'hF0); send(8'h1E);
        drain();
        check("brk_hv_count", hv_cnt - hv0, 1);
        check("brk_value", value, 32'h0000_0002);

        // Bad parity and bad stop
        exp_err();
        send(8'h16, 1'b1, 1'b1);
        exp_err();
        send(8'h16, 1'b0, 1'b0);
        drain();
        check("bad_frame_value", value, 32'h0000_0002);

        // Timeout after 5 falling edges
        exp_err();
        send_raw({1'b1, 1'b0, 8'h45, 1'b0}, 5);
        cyc(TMO + 200);
        drain();
        exp_hex(4'h0, 32'h0000_0020);
        send(8'h45);
        drain();

        // Short clock glitches while idle
        hv0 = hv_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i < 6; i++) begin
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(20);
        end
        cyc(50);
        check("glitch_err", fe_cnt - fe0, 0);
        check("glitch_hv", hv_cnt - hv0, 0);

        // Reset mid-frame
        send_raw({1'b1, 1'b0, 8'h1E, 1'b0}, 4);
        rst_n = 1'b0;
        cyc(3);
        check("mid_rst_hex", {28'd0, hex}, 32'h0);
        check("mid_rst_value", value, 32'h0);
        check("mid_rst_pulses", {30'd0, hex_valid, frame_err}, 32'h0);
        rst_n = 1'b1;
        cyc(20);
        exp_hex(4'h1, 32'h0000_0001);
        send(8'h16);
        drain();
        send(8'h66);
        drain();
        check("final_bksp", value, 32'h0);

        cyc(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_hex_entry.md
# ps2_hex_entry

Receives PS/2 keyboard frames from the Nexys A7 USB-HID bridge and decodes them into hex digits. The digits feed the 8-digit seven-segment display path. The block synchronises and filters the PS/2 clock, deserialises 11-bit frames, checks parity and framing, then tracks set-2 make and break codes. Each accepted 0-9/A-F keypress produces a 4-bit digit and shifts it into a 32-bit display value.

## Interface
- FILTER_LEN, 8: consecutive identical `clk` samples needed before filtered PS2_CLK changes level.
- TIMEOUT_CYCLES, 200000: idle `clk` cycles allowed between PS/2 falling edges mid-frame (2 ms at 100 MHz).
- clk  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  reset; one clock; reset is asynchronous and active-low.
- PS2_CLK  in  1  PS/2 clock from the bridge; asynchronous to `clk`.
- PS2_DATA  in  1  PS/2 data from the bridge; asynchronous to `clk`.
- hex  out  4  last accepted digit.
- hex_valid  out  1  one-cycle pulse when `hex` updates.
- value  out  32  last 8 digits entered; newest digit is in [3:0].
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Both PS/2 inputs pass through 2-FF synchronisers.
- Filtered PS2_CLK (`fclk`) takes the synchronised level only after FILTER_LEN equal consecutive samples.
- A falling edge of `fclk` samples synchronised PS2_DATA.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge, data 0 goes to DATA with bit count 0. Data 1 is an invalid start: pulse frame_err and stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: the byte is good if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). A good byte raises an internal byte strobe. Otherwise pulse frame_err. Either way return to IDLE.
- Timeout: in DATA, PARITY or STOP, if no falling edge arrives for TIMEOUT_CYCLES, pulse frame_err, return to IDLE and discard the partial byte. The timeout counter clears on every falling edge and in IDLE.
- Decoder: two flags, brk and ext, applied to each good byte.
  - 0xF0 sets brk. 0xE0 sets ext.
  - Any other byte with brk or ext set is ignored, and both flags clear.
  - Otherwise the byte is looked up as a make code.
- Make-code map: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9, 1C→A, 32→B, 21→C, 23→D, 24→E, 2B→F.
  - On a hit: hex ← digit, value ← {value[27:0], digit}, hex_valid pulses.
- Make code 0x66 (Backspace): value ← 0. No hex_valid.
- Any other make code is ignored.
- Reset values: hex=0, hex_valid=0, value=0, frame_err=0, FSM=IDLE, brk=ext=0, filter state=1, sync regs=1.
- Reset asserted mid-frame aborts the frame. The next frame starts clean after release.

## Timing
- `fclk` falling edge is detected at most 2+FILTER_LEN+1 cycles after the PS2_CLK pad edge.
- Byte strobe is registered one cycle after the STOP-bit falling edge.
- hex, value and hex_valid update one cycle after the byte strobe.
- frame_err is registered one cycle after the failing edge or the timeout expiry.
- hex_valid and frame_err never assert in the same cycle. A byte either succeeds or fails.
- Glitches on PS2_CLK shorter than FILTER_LEN cycles produce no edge.
- value shifts with wrap: the oldest digit [31:28] is discarded.

## Test plan
- Frame 0x16 (bits 0,0,1,1,0,1,0,0,0,p=0,1) → hex=1, hex_valid one pulse, value=0x00000001.
- Sequence 1C,32,21,23,24,2B,45,16,1E → value=0x BCDEF012 (first digit A shifted out). frame_err never asserts.
- Sequence 1E, F0 1E, E0 1E, E0 F0 1E → exactly one hex_valid, value=0x00000002.
- Frame 0x16 with parity=1 → frame_err pulse, no hex_valid, value unchanged. Frame with stop=0 → same result.
- 5 falling edges then 3 ms silence → frame_err pulse after TIMEOUT_CYCLES. A following valid 0x45 → hex=0, value shifts in 0.
- 3-cycle PS2_CLK glitches during idle → no frame_err. CPU_RESETN low mid-frame → all outputs 0, next full frame decodes correctly. 0x66 → value=0.
